// File: rtl/motion_frame_collector.sv
// Drain-side consumer of the motion-detect pixel stream: pops pixels from a show-ahead FIFO,
// tracks raster position and produces a per-frame hit count and bounding box under valid/ack.
module motion_frame_collector #(
    parameter int                    DATA_WIDTH      = 24,
    parameter int                    IMG_WIDTH       = 720,
    parameter int                    IMG_HEIGHT      = 540,
    parameter logic [DATA_WIDTH-1:0] HIGHLIGHT_COLOR = 24'hFF0000,
    localparam int                   X_W             = $clog2(IMG_WIDTH),
    localparam int                   Y_W             = $clog2(IMG_HEIGHT),
    localparam int                   CNT_W           = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic [CNT_W-1:0]      motion_count,
    output logic [X_W-1:0]        bbox_xmin,
    output logic [X_W-1:0]        bbox_xmax,
    output logic [Y_W-1:0]        bbox_ymin,
    output logic [Y_W-1:0]        bbox_ymax,
    output logic [15:0]           frame_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [X_W-1:0]     acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [Y_W-1:0]     acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [X_W-1:0]     out_xmin_q, out_xmin_d, out_xmax_q, out_xmax_d;
    logic [Y_W-1:0]     out_ymin_q, out_ymin_d, out_ymax_q, out_ymax_d;
    logic               frame_valid_q, frame_valid_d;
    logic [15:0]        frame_count_q, frame_count_d;

    logic               pop_s;
    logic               hit_s;
    logic [CNT_W-1:0]   cnt_n_s;
    logic [X_W-1:0]     xmin_n_s, xmax_n_s;
    logic [Y_W-1:0]     ymin_n_s, ymax_n_s;

    // Next-state: pixel consumption, accumulator update and summary handshake.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        acc_cnt_d     = acc_cnt_q;
        acc_xmin_d    = acc_xmin_q;
        acc_xmax_d    = acc_xmax_q;
        acc_ymin_d    = acc_ymin_q;
        acc_ymax_d    = acc_ymax_q;
        out_cnt_d     = out_cnt_q;
        out_xmin_d    = out_xmin_q;
        out_xmax_d    = out_xmax_q;
        out_ymin_d    = out_ymin_q;
        out_ymax_d    = out_ymax_q;
        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;

        pop_s   = (state_q == ST_RUN) && !in_empty && !reset;
        hit_s   = (in_dout == HIGHLIGHT_COLOR);
        cnt_n_s = acc_cnt_q + {{(CNT_W-1){1'b0}}, hit_s};

        if (hit_s && (x_q < acc_xmin_q)) xmin_n_s = x_q; else xmin_n_s = acc_xmin_q;
        if (hit_s && (x_q > acc_xmax_q)) xmax_n_s = x_q; else xmax_n_s = acc_xmax_q;
        if (hit_s && (y_q < acc_ymin_q)) ymin_n_s = y_q; else ymin_n_s = acc_ymin_q;
        if (hit_s && (y_q > acc_ymax_q)) ymax_n_s = y_q; else ymax_n_s = acc_ymax_q;

        case (state_q)
            ST_RUN: begin
                if (pop_s) begin
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                        state_d       = ST_HOLD;
                        x_d           = {X_W{1'b0}};
                        y_d           = {Y_W{1'b0}};
                        acc_cnt_d     = {CNT_W{1'b0}};
                        acc_xmin_d    = {X_W{1'b1}};
                        acc_xmax_d    = {X_W{1'b0}};
                        acc_ymin_d    = {Y_W{1'b1}};
                        acc_ymax_d    = {Y_W{1'b0}};
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        // A frame without hits reports an all-zero box, not the min sentinels.
                        if (cnt_n_s == {CNT_W{1'b0}}) begin
                            out_cnt_d  = {CNT_W{1'b0}};
                            out_xmin_d = {X_W{1'b0}};
                            out_xmax_d = {X_W{1'b0}};
                            out_ymin_d = {Y_W{1'b0}};
                            out_ymax_d = {Y_W{1'b0}};
                        end else begin
                            out_cnt_d  = cnt_n_s;
                            out_xmin_d = xmin_n_s;
                            out_xmax_d = xmax_n_s;
                            out_ymin_d = ymin_n_s;
                            out_ymax_d = ymax_n_s;
                        end
                    end else begin
                        acc_cnt_d  = cnt_n_s;
                        acc_xmin_d = xmin_n_s;
                        acc_xmax_d = xmax_n_s;
                        acc_ymin_d = ymin_n_s;
                        acc_ymax_d = ymax_n_s;
                        if (x_q == X_LAST) begin
                            x_d = {X_W{1'b0}};
                            y_d = y_q + {{(Y_W-1){1'b0}}, 1'b1};
                        end else begin
                            x_d = x_q + {{(X_W-1){1'b0}}, 1'b1};
                            y_d = y_q;
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    state_d       = ST_RUN;
                    frame_valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and summary registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            x_q           <= {X_W{1'b0}};
            y_q           <= {Y_W{1'b0}};
            acc_cnt_q     <= {CNT_W{1'b0}};
            acc_xmin_q    <= {X_W{1'b1}};
            acc_xmax_q    <= {X_W{1'b0}};
            acc_ymin_q    <= {Y_W{1'b1}};
            acc_ymax_q    <= {Y_W{1'b0}};
            out_cnt_q     <= {CNT_W{1'b0}};
            out_xmin_q    <= {X_W{1'b0}};
            out_xmax_q    <= {X_W{1'b0}};
            out_ymin_q    <= {Y_W{1'b0}};
            out_ymax_q    <= {Y_W{1'b0}};
            frame_valid_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_xmin_q    <= acc_xmin_d;
            acc_xmax_q    <= acc_xmax_d;
            acc_ymin_q    <= acc_ymin_d;
            acc_ymax_q    <= acc_ymax_d;
            out_cnt_q     <= out_cnt_d;
            out_xmin_q    <= out_xmin_d;
            out_xmax_q    <= out_xmax_d;
            out_ymin_q    <= out_ymin_d;
            out_ymax_q    <= out_ymax_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign in_rd_en     = pop_s;
    assign frame_valid  = frame_valid_q;
    assign motion_count = out_cnt_q;
    assign bbox_xmin    = out_xmin_q;
    assign bbox_xmax    = out_xmax_q;
    assign bbox_ymin    = out_ymin_q;
    assign bbox_ymax    = out_ymax_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_motion_frame_collector.sv
// Scoreboard bench for motion_frame_collector on a 4x3 image: a FIFO model feeds pixels,
// a reference model predicts each frame summary, and a monitor checks and acknowledges it.
module tb_motion_frame_collector;

    localparam int          W     = 4;
    localparam int          H     = 3;
    localparam int          N     = W * H;
    localparam logic [23:0] HL    = 24'hFF0000;
    localparam int          X_W   = 2;
    localparam int          Y_W   = 2;
    localparam int          CNT_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_empty;
    logic              in_rd_en;
    logic [23:0]       in_dout;
    logic              frame_valid;
    logic              frame_ack;
    logic [CNT_W-1:0]  motion_count;
    logic [X_W-1:0]    bbox_xmin, bbox_xmax;
    logic [Y_W-1:0]    bbox_ymin, bbox_ymax;
    logic [15:0]       frame_count;

    motion_frame_collector #(
        .DATA_WIDTH(24), .IMG_WIDTH(W), .IMG_HEIGHT(H), .HIGHLIGHT_COLOR(HL)
    ) dut (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en),
        .in_dout(in_dout), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .motion_count(motion_count), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cnt; int xmin; int xmax; int ymin; int ymax; int fc; int ack_dly;
    } summ_t;

    summ_t       exp_q[$];
    logic [23:0] pix_q[$];
    bit          last_q[$];
    logic [23:0] fbuf [N];
    int          vectors = 0;
    int          miscompares = 0;
    int          model_fc = 0;
    int          gap_mode = 0;
    bit          mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: summary of a whole frame from raster index arithmetic.
    task automatic push_frame(input int ack_dly);
        summ_t s;
        s.cnt = 0; s.xmin = W; s.xmax = -1; s.ymin = H; s.ymax = -1;
        for (int i = 0; i < N; i++) begin
            if (fbuf[i] == HL) begin
                s.cnt++;
                if (i % W < s.xmin) s.xmin = i % W;
                if (i % W > s.xmax) s.xmax = i % W;
                if (i / W < s.ymin) s.ymin = i / W;
                if (i / W > s.ymax) s.ymax = i / W;
            end
        end
        if (s.cnt == 0) begin
            s.xmin = 0; s.xmax = 0; s.ymin = 0; s.ymax = 0;
        end
        model_fc  = (model_fc + 1) % 65536;
        s.fc      = model_fc;
        s.ack_dly = ack_dly;
        exp_q.push_back(s);
        for (int i = 0; i < N; i++) begin
            pix_q.push_back(fbuf[i]);
            last_q.push_back(i == N - 1);
        end
    endtask

    function automatic logic [23:0] non_hit();
        logic [23:0] v;
        v = 24'($urandom);
        if ($urandom_range(0, 3) == 0) v = HL ^ (24'd1 << $urandom_range(0, 23));
        if (v == HL) v = 24'h000000;
        return v;
    endfunction

    task automatic cmp_summary(input summ_t s, input string tag);
        chk({tag, "_count"}, 32'(motion_count), s.cnt);
        chk({tag, "_xmin"},  32'(bbox_xmin),    s.xmin);
        chk({tag, "_xmax"},  32'(bbox_xmax),    s.xmax);
        chk({tag, "_ymin"},  32'(bbox_ymin),    s.ymin);
        chk({tag, "_ymax"},  32'(bbox_ymax),    s.ymax);
        chk({tag, "_fcount"}, 32'(frame_count), s.fc);
    endtask

    // Upstream FIFO model: show-ahead head, pops on sampled rd_en, optional gaps.
    initial begin
        bit rd;
        bit gap;
        bit tgl = 1'b0;
        bit expect_fv = 1'b0;
        in_empty = 1'b1;
        in_dout  = 24'h000000;
        forever begin
            @(negedge clock);
            rd = in_rd_en;
            if (expect_fv) begin
                chk("latency_fv", 32'(frame_valid), 1);
                expect_fv = 1'b0;
            end
            chk("rd_guard", 32'(rd && (in_empty || frame_valid || reset)), 0);
            if (rd && last_q.size() > 0 && last_q[0]) expect_fv = 1'b1;
            @(posedge clock);
            #1;
            if (rd) begin
                chk("pop_underflow", 32'(pix_q.size() > 0), 1);
                if (pix_q.size() > 0) begin
                    void'(pix_q.pop_front());
                    void'(last_q.pop_front());
                end
            end
            tgl = ~tgl;
            case (gap_mode)
                1:       gap = tgl;
                2:       gap = ($urandom_range(0, 3) == 0);
                default: gap = 1'b0;
            endcase
            in_empty = (pix_q.size() == 0) || gap;
            in_dout  = (pix_q.size() > 0) ? pix_q[0] : 24'($urandom);
        end
    end

    // Monitor: compare each presented summary, hold for ack_dly cycles, then acknowledge.
    initial begin
        summ_t cur;
        frame_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (frame_valid === 1'b1 && reset === 1'b0) begin
                mon_busy = 1'b1;
                chk("frame_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    cmp_summary(cur, "sum");
                    for (int k = 0; k < cur.ack_dly; k++) begin
                        @(negedge clock);
                        chk("hold_valid", 32'(frame_valid), 1);
                        cmp_summary(cur, "hold");
                    end
                end
                @(posedge clock);
                #1 frame_ack = 1'b1;
                @(posedge clock);
                #1 frame_ack = 1'b0;
                @(negedge clock);
                chk("ack_drop", 32'(frame_valid), 0);
                if (!in_empty) chk("resume_pop", 32'(in_rd_en), 1);
                cmp_summary(cur, "retain");
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((pix_q.size() != 0 || exp_q.size() != 0 || frame_valid !== 1'b0 || mon_busy)
               && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", 32'(n < 3000), 1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < N; i++) fbuf[i] = 24'h000000;
        push_frame(0);
        repeat (3) begin
            @(negedge clock);
            chk("rst_rd_en", 32'(in_rd_en), 0);
            chk("rst_valid", 32'(frame_valid), 0);
            chk("rst_count", 32'(motion_count), 0);
            chk("rst_bbox", 32'({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 0);
            chk("rst_fcount", 32'(frame_count), 0);
        end
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < N; i++) fbuf[i] = 24'h000000;
        fbuf[1] = HL; fbuf[11] = HL;
        push_frame(10);
        for (int i = 0; i < N; i++) fbuf[i] = non_hit();
        fbuf[6] = HL;
        push_frame(2);
        wait_idle();

        gap_mode = 1;
        for (int i = 0; i < N; i++) fbuf[i] = 24'h000000;
        fbuf[4] = HL;
        push_frame(1);
        wait_idle();
        gap_mode = 0;

        for (int i = 0; i < 5; i++) begin
            pix_q.push_back((i == 0) ? HL : 24'h000000);
            last_q.push_back(1'b0);
        end
        n = 0;
        while (pix_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("partial_drain", 32'(n < 200), 1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        model_fc = 0;
        @(negedge clock);
        chk("mid_rst_fcount", 32'(frame_count), 0);
        chk("mid_rst_valid", 32'(frame_valid), 0);
        chk("mid_rst_count", 32'(motion_count), 0);
        for (int i = 0; i < N; i++) fbuf[i] = 24'h000000;
        fbuf[10] = HL;
        push_frame(3);
        wait_idle();

        gap_mode = 2;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < N; i++)
                fbuf[i] = ($urandom_range(0, 3) == 0) ? HL : non_hit();
            if (f == 3) for (int i = 0; i < N; i++) fbuf[i] = non_hit();
            push_frame(int'($urandom_range(0, 4)));
            if (f % 2 == 1) wait_idle();
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
